pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of the high-time and period counters and of their outputs.
REQ-002 Parameter TIMEOUT, default 1000: clock count without a synchronized edge after which the input is declared stuck; must be less than 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pwm_in  input  1  asynchronous PWM signal to be measured.
REQ-006 enable  input  1  1 = measure; 0 = hold outputs and return the FSM to WAIT_RISE.
REQ-007 high_cnt  output  CNT_W  clk cycles high in the last complete period.
REQ-008 period_cnt  output  CNT_W  clk cycles between the last two rising edges.
REQ-009 duty_tenths  output  4  floor(10*high_cnt/period_cnt), range 0..10.
REQ-010 meas_valid  output  1  one-cycle pulse when all result outputs update together.
REQ-011 stuck_high, stuck_low  output  1 each  level flags for no activity on pwm_in.
REQ-012 missed  output  1  sticky flag: a period completed while the divider was busy.

Function
REQ-013 pwm_in shall pass through a 2-FF synchronizer plus one history FF; rise_det = s2 & ~s3, fall_det = ~s2 & s3.
REQ-014 Measurement FSM states: WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-015 WAIT_RISE: on rise_det -> MEAS_HIGH, and run_cnt and hi_acc are loaded with 1.
REQ-016 MEAS_HIGH: run_cnt and hi_acc increment each cycle; on fall_det -> MEAS_LOW, and hi_acc freezes.
REQ-017 MEAS_LOW: run_cnt increments; on rise_det the period completes, {hi_acc, run_cnt} is latched as a candidate, the counters reload to 1, and the FSM goes to MEAS_HIGH.
REQ-018 Rise-to-rise spacing N clocks shall yield period_cnt = N, and rise-to-fall spacing H shall yield high_cnt = H.
REQ-019 Divider states: DIV_IDLE, DIV_BUSY.
REQ-020 On a completed period while in DIV_IDLE: acc = 10*hi (CNT_W+4 bits), q = 0, go to DIV_BUSY.
REQ-021 DIV_BUSY: each cycle, if acc >= period then acc -= period and q++; otherwise, in that same cycle, load high_cnt, period_cnt and duty_tenths = q, pulse meas_valid, and go to DIV_IDLE.
REQ-022 meas_valid latency after the completing rise_det shall be q+2 cycles, i.e. at most 12 cycles.
REQ-023 If a period completes while in DIV_BUSY, that period is discarded, missed is set, and counting continues normally.
REQ-024 Stuck detection: if run_cnt reaches TIMEOUT in MEAS_HIGH, set stuck_high; if it reaches TIMEOUT in MEAS_LOW or WAIT_RISE (WAIT_RISE counts from enable/reset), set stuck_low.
REQ-025 On stuck: high_cnt = 0, period_cnt = 0, duty_tenths = 10 (high) or 0 (low), a single meas_valid pulse, and the FSM goes to WAIT_RISE.
REQ-026 The stuck condition shall generate no further meas_valid pulses; the stuck flag clears on the next rise_det or fall_det.
REQ-027 run_cnt and hi_acc shall saturate at 2^CNT_W-1 and never wrap.
REQ-028 enable=0 shall not clear missed, the stuck flags or the outputs.
REQ-029 If enable falls during DIV_BUSY, the division completes and reports.
REQ-030 If fall_det and a stuck timeout occur in the same cycle, the edge wins and no stuck flag is set.
REQ-031 The first rise after WAIT_RISE never produces a measurement; the first meas_valid requires two rises.

Reset
REQ-032 rst=1 at a clk edge shall clear all outputs to 0, clear the synchronizer, FSM to WAIT_RISE, divider to DIV_IDLE, missed = 0, and clear run_cnt, hi_acc, acc and q.
REQ-033 rst asserted mid-measurement or mid-division shall abandon that result with no meas_valid pulse.
REQ-034 Reset overrides enable and all edge events in the same cycle.

Verification
REQ-035 Period 10, high 5, repeated -> high_cnt=5, period_cnt=10, duty_tenths=5, meas_valid once per period after the second rise.
REQ-036 Period 100, high 99 -> duty_tenths=9; period 100, high 1 -> duty_tenths=0.
REQ-037 pwm_in held high for longer than TIMEOUT -> stuck_high=1, duty_tenths=10, exactly one meas_valid; the next falling edge -> stuck_high=0.
REQ-038 Period 8 (less than the divider time) -> missed=1, and every second period is still reported correctly.
REQ-039 rst pulsed 3 cycles after a completing rise -> no meas_valid, all outputs 0, and the first new result appears only after two fresh rises.
REQ-040 enable=0 for 50 cycles mid-stream -> outputs held; after re-enable, the first result appears after two rises.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes pwm_in, measures high time and period in clk cycles, reports
// duty in tenths through a sequential subtract-and-count divider, and flags a stuck input.
module pwm_capture #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   input  logic             enable,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic [3:0]       duty_tenths,
   output logic             meas_valid,
   output logic             stuck_high,
   output logic             stuck_low,
   output logic             missed
);

   localparam int               ACC_W     = CNT_W + 4;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} meas_state_t;
   typedef enum logic       {DIV_IDLE, DIV_BUSY}             div_state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   logic s1, s2, s3;
   logic rise_det, fall_det;

   // NOTE: non-blocking assignments make every stage take the previous stage's old value,
   // so the chain really is three flops regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= pwm_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise_det = s2 & ~s3;
   assign fall_det = ~s2 & s3;

   meas_state_t      state, state_d;
   logic [CNT_W-1:0] run_cnt, run_cnt_d;
   logic [CNT_W-1:0] hi_acc, hi_acc_d;
   logic             period_done, stuck_hi_evt, stuck_lo_evt;
   logic             timed_out, no_flag;

   assign timed_out = (run_cnt >= TIMEOUT_C);
   assign no_flag   = ~stuck_high & ~stuck_low;

   // NOTE: every signal gets a default before the case so no path leaves one unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d      = state;
      run_cnt_d    = run_cnt;
      hi_acc_d     = hi_acc;
      period_done  = 1'b0;
      stuck_hi_evt = 1'b0;
      stuck_lo_evt = 1'b0;
      if (!enable) begin
         state_d   = WAIT_RISE;
         run_cnt_d = '0;
      end else begin
         case (state)
            WAIT_RISE: begin
               if (rise_det) begin
                  state_d   = MEAS_HIGH;
                  run_cnt_d = CNT_W'(1);
                  hi_acc_d  = CNT_W'(1);
               end else if (fall_det) begin
                  run_cnt_d = CNT_W'(1);
               end else if (timed_out && no_flag) begin
                  stuck_lo_evt = 1'b1;
                  run_cnt_d    = '0;
               end else begin
                  run_cnt_d = sat_inc(run_cnt);
               end
            end
            MEAS_HIGH: begin
               if (fall_det) begin
                  state_d   = MEAS_LOW;
                  run_cnt_d = sat_inc(run_cnt);
               end else if (timed_out) begin
                  stuck_hi_evt = 1'b1;
                  state_d      = WAIT_RISE;
                  run_cnt_d    = '0;
               end else begin
                  run_cnt_d = sat_inc(run_cnt);
                  hi_acc_d  = sat_inc(hi_acc);
               end
            end
            MEAS_LOW: begin
               if (rise_det) begin
                  period_done = 1'b1;
                  state_d     = MEAS_HIGH;
                  run_cnt_d   = CNT_W'(1);
                  hi_acc_d    = CNT_W'(1);
               end else if (timed_out) begin
                  stuck_lo_evt = 1'b1;
                  state_d      = WAIT_RISE;
                  run_cnt_d    = '0;
               end else begin
                  run_cnt_d = sat_inc(run_cnt);
               end
            end
            default: begin
               state_d   = WAIT_RISE;
               run_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= WAIT_RISE;
         run_cnt <= '0;
         hi_acc  <= '0;
      end else begin
         state   <= state_d;
         run_cnt <= run_cnt_d;
         hi_acc  <= hi_acc_d;
      end
   end

   div_state_t       div_state, div_state_d;
   logic             div_start, div_step, div_report;
   logic [ACC_W-1:0] div_acc, div_den, hi_ext;
   logic [3:0]       div_q;
   logic [CNT_W-1:0] div_period, div_hi;

   assign div_den = {4'b0000, div_period};
   assign hi_ext  = {4'b0000, hi_acc};

   always_comb begin
      div_state_d = div_state;
      div_start   = 1'b0;
      div_step    = 1'b0;
      div_report  = 1'b0;
      case (div_state)
         DIV_IDLE: begin
            if (period_done) begin
               div_start   = 1'b1;
               div_state_d = DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            if (div_acc >= div_den) begin
               div_step = 1'b1;
            end else begin
               div_report  = 1'b1;
               div_state_d = DIV_IDLE;
            end
         end
      endcase
   end

   // NOTE: the divider datapath is reset along with the control state so an abandoned
   // division can never leak a stale quotient into a later report.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_state  <= DIV_IDLE;
         div_acc    <= '0;
         div_q      <= '0;
         div_period <= '0;
         div_hi     <= '0;
      end else begin
         div_state <= div_state_d;
         if (div_start) begin
            div_acc    <= (hi_ext << 3) + (hi_ext << 1);
            div_q      <= '0;
            div_period <= run_cnt;
            div_hi     <= hi_acc;
         end else if (div_step) begin
            div_acc <= div_acc - div_den;
            div_q   <= div_q + 4'd1;
         end
      end
   end

   // Stuck reports are written after the divider report so they take precedence.
   always_ff @(posedge clk) begin
      if (rst) begin
         high_cnt    <= '0;
         period_cnt  <= '0;
         duty_tenths <= '0;
         meas_valid  <= 1'b0;
         stuck_high  <= 1'b0;
         stuck_low   <= 1'b0;
         missed      <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (period_done && (div_state == DIV_BUSY)) missed <= 1'b1;
         if (div_report) begin
            high_cnt    <= div_hi;
            period_cnt  <= div_period;
            duty_tenths <= div_q;
            meas_valid  <= 1'b1;
         end
         if (stuck_hi_evt || stuck_lo_evt) begin
            high_cnt    <= '0;
            period_cnt  <= '0;
            duty_tenths <= stuck_hi_evt ? 4'd10 : 4'd0;
            meas_valid  <= 1'b1;
         end
         if (stuck_hi_evt)                            stuck_high <= 1'b1;
         else if (enable && (rise_det || fall_det))   stuck_high <= 1'b0;
         if (stuck_lo_evt)                            stuck_low  <= 1'b1;
         else if (enable && (rise_det || fall_det))   stuck_low  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of PWM patterns with hand-computed results, plus
// sequences for stuck detection, reset mid-division and enable gating.
module tb_pwm_capture;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 200;

   logic             clk;
   logic             rst;
   logic             pwm_in;
   logic             enable;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic [3:0]       duty_tenths;
   logic             meas_valid;
   logic             stuck_high;
   logic             stuck_low;
   logic             missed;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .enable      (enable),
      .high_cnt    (high_cnt),
      .period_cnt  (period_cnt),
      .duty_tenths (duty_tenths),
      .meas_valid  (meas_valid),
      .stuck_high  (stuck_high),
      .stuck_low   (stuck_low),
      .missed      (missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int high;
      int period;
      int duty;
      int t;
   } result_t;

   result_t res_q[$];

   always @(negedge clk) begin
      if (meas_valid === 1'b1)
         res_q.push_back('{int'(high_cnt), int'(period_cnt), int'(duty_tenths), cyc});
   end

   typedef struct {
      int hi;
      int lo;
      int n;
      int e_high;
      int e_per;
      int e_duty;
      int e_pulses;
      int e_missed;
   } vec_t;

   vec_t vecs[6];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      pwm_in = 1'b0;
      enable = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
      res_q.delete();
   endtask

   // Starts a rise now, holds high for hi cycles then low for lo cycles.
   task automatic drive_period(input int hi, input int lo, output int rise_t);
      pwm_in = 1'b1;
      rise_t = cyc;
      wait_cycles(hi);
      pwm_in = 1'b0;
      wait_cycles(lo);
   endtask

   function automatic result_t last_result();
      result_t r;
      r = '{-1, -1, -1, -1};
      if (res_q.size() > 0) r = res_q[res_q.size()-1];
      return r;
   endfunction

   initial begin
      int      rise_t;
      int      k;
      result_t r;

      rst    = 1'b1;
      pwm_in = 1'b0;
      enable = 1'b1;

      //            hi  lo  n  e_high e_per e_duty pulses missed
      vecs[0] = '{  5,  5, 4,     5,   10,    5,     4,    0};
      vecs[1] = '{ 99,  1, 2,    99,  100,    9,     2,    0};
      vecs[2] = '{  1, 99, 2,     1,  100,    0,     2,    0};
      vecs[3] = '{  3,  7, 3,     3,   10,    3,     3,    0};
      vecs[4] = '{  8,  2, 3,     8,   10,    8,     3,    0};
      vecs[5] = '{  7,  1, 4,     7,    8,    8,     2,    1};

      do_reset();
      check("rst_high_cnt",   high_cnt,    0);
      check("rst_period_cnt", period_cnt,  0);
      check("rst_duty",       duty_tenths, 0);
      check("rst_meas_valid", meas_valid,  0);
      check("rst_stuck_high", stuck_high,  0);
      check("rst_stuck_low",  stuck_low,   0);
      check("rst_missed",     missed,      0);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int p = 0; p <= vecs[v].n; p++) drive_period(vecs[v].hi, vecs[v].lo, rise_t);
         wait_cycles(15);
         r = last_result();
         check($sformatf("v%0d_pulses", v), res_q.size(), vecs[v].e_pulses);
         check($sformatf("v%0d_high", v),   r.high,       vecs[v].e_high);
         check($sformatf("v%0d_period", v), r.period,     vecs[v].e_per);
         check($sformatf("v%0d_duty", v),   r.duty,       vecs[v].e_duty);
         check($sformatf("v%0d_missed", v), missed,       vecs[v].e_missed);
         check($sformatf("v%0d_stuck", v),  {stuck_high, stuck_low}, 0);
         if (vecs[v].e_missed == 0)
            check($sformatf("v%0d_latency", v), r.t, rise_t + 4 + vecs[v].e_duty);
      end

      // Stuck high, release, stuck low, release.
      do_reset();
      pwm_in = 1'b1;
      k = cyc;
      wait_cycles(250);
      r = last_result();
      check("sh_pulses",     res_q.size(), 1);
      check("sh_time",       r.t,          k + 3 + TIMEOUT);
      check("sh_duty",       r.duty,       10);
      check("sh_high_cnt",   r.high,       0);
      check("sh_period_cnt", r.period,     0);
      check("sh_flag",       stuck_high,   1);
      check("sh_low_flag",   stuck_low,    0);
      pwm_in = 1'b0;
      wait_cycles(5);
      check("sh_clear",      stuck_high,   0);
      check("sh_no_repeat",  res_q.size(), 1);
      wait_cycles(210);
      r = last_result();
      check("sl_flag",       stuck_low,    1);
      check("sl_pulses",     res_q.size(), 2);
      check("sl_duty",       r.duty,       0);
      wait_cycles(50);
      check("sl_no_repeat",  res_q.size(), 2);
      pwm_in = 1'b1;
      wait_cycles(5);
      check("sl_clear",      stuck_low,    0);

      // Reset three cycles after a completing rise abandons the division.
      do_reset();
      drive_period(5, 5, rise_t);
      drive_period(5, 5, rise_t);
      check("rd_pre_pulses", res_q.size(), 1);
      pwm_in = 1'b1;
      wait_cycles(5);
      pwm_in = 1'b0;
      rst    = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      check("rd_high_cnt",   high_cnt,    0);
      check("rd_period_cnt", period_cnt,  0);
      check("rd_duty",       duty_tenths, 0);
      wait_cycles(14);
      check("rd_no_pulse",   res_q.size(), 1);
      drive_period(5, 5, rise_t);
      check("rd_first_rise", res_q.size(), 1);
      drive_period(5, 5, rise_t);
      r = last_result();
      check("rd_second_rise", res_q.size(), 2);
      check("rd_new_duty",    r.duty,       5);

      // Enable drops mid-division, stays low ~50 cycles, then re-enabled.
      do_reset();
      drive_period(5, 5, rise_t);
      drive_period(5, 5, rise_t);
      pwm_in = 1'b1;
      wait_cycles(5);
      pwm_in = 1'b0;
      enable = 1'b0;
      wait_cycles(10);
      check("en_div_done", res_q.size(), 2);
      for (int p = 0; p < 4; p++) drive_period(3, 7, rise_t);
      check("en_hold_pulses", res_q.size(), 2);
      check("en_hold_high",   high_cnt,     5);
      check("en_hold_period", period_cnt,   10);
      check("en_hold_duty",   duty_tenths,  5);
      enable = 1'b1;
      drive_period(3, 7, rise_t);
      check("en_first_rise", res_q.size(), 2);
      drive_period(3, 7, rise_t);
      r = last_result();
      check("en_second_rise", res_q.size(), 3);
      check("en_new_high",    r.high,       3);
      check("en_new_duty",    r.duty,       3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
